vedic_mult_pipe: RTL and testbench

VEDIC_MULT_PIPE -- requirements
Module: vedic_mult_pipe

---
 rtl/vedic_pkg.sv | 12 +
 rtl/vedic_nxn.sv | 36 +++
 rtl/vedic_mult_pipe.sv | 104 ++++++++++
 tb/tb_vedic_mult_pipe.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/vedic_pkg.sv
// Shared constants for the Vedic multiplier pipeline: stage count, latency
// and the legal operand-width check used at elaboration.
package vedic_pkg;

  localparam int unsigned VEDIC_STAGES  = 3;
  localparam int unsigned VEDIC_LATENCY = VEDIC_STAGES;

  function automatic bit width_legal(input int unsigned w);
    return (w == 4) || (w == 8) || (w == 16) || (w == 32);
  endfunction

endpackage

// File: rtl/vedic_nxn.sv
// Combinational recursive Urdhva-Tiryagbhyam multiplier, N x N unsigned,
// built from four N/2 x N/2 products down to a 2x2 leaf.
module vedic_nxn #(
  parameter int unsigned N = 2
) (
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic [2*N-1:0] p
);

  localparam int unsigned H = N / 2;

  if (N == 2) begin : g_leaf
    logic [1:0] w_cross;
    always_comb begin
      w_cross = {1'b0, a[1] & b[0]} + {1'b0, a[0] & b[1]};
      p       = {1'b0, a[1] & b[1], 2'b00} + {1'b0, w_cross, 1'b0}
              + {3'b000, a[0] & b[0]};
    end
  end else begin : g_rec
    logic [N-1:0] w_ll, w_hl, w_lh, w_hh;
    logic [N:0]   w_mid;

    vedic_nxn #(.N(H)) u_ll (.a(a[H-1:0]), .b(b[H-1:0]), .p(w_ll));
    vedic_nxn #(.N(H)) u_hl (.a(a[N-1:H]), .b(b[H-1:0]), .p(w_hl));
    vedic_nxn #(.N(H)) u_lh (.a(a[H-1:0]), .b(b[N-1:H]), .p(w_lh));
    vedic_nxn #(.N(H)) u_hh (.a(a[N-1:H]), .b(b[N-1:H]), .p(w_hh));

    // Vertical terms concatenate without overlap; only the crosswise sum adds.
    always_comb begin
      w_mid = {1'b0, w_hl} + {1'b0, w_lh};
      p     = {w_hh, w_ll} + {{(H-1){1'b0}}, w_mid, {H{1'b0}}};
    end
  end

endmodule

// File: rtl/vedic_mult_pipe.sv
// Three-stage signed/unsigned Vedic multiplier: magnitudes, partial products,
// summed and sign-corrected product; one global stall enable for all stages.
module vedic_mult_pipe
  import vedic_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_signed,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p,
  output logic [TAG_W-1:0]   out_tag
);

  localparam int unsigned H = WIDTH / 2;

  if (!width_legal(WIDTH)) begin : g_bad_width
    $error("vedic_mult_pipe: WIDTH must be 4, 8, 16 or 32");
  end

  logic               w_en;
  logic               w_a_neg, w_b_neg;
  logic [WIDTH-1:0]   w_ma, w_mb;
  logic [WIDTH-1:0]   w_q0, w_q1, w_q2, w_q3;
  logic [2*WIDTH-1:0] w_sum, w_prod;

  logic               r_v1, r_v2, r_v3;
  logic [WIDTH-1:0]   r_ma, r_mb;
  logic               r_neg1, r_neg2;
  logic [TAG_W-1:0]   r_tag1, r_tag2, r_tag3;
  logic [WIDTH-1:0]   r_q0, r_q1, r_q2, r_q3;
  logic [2*WIDTH-1:0] r_p;

  assign w_en      = !r_v3 || out_ready;
  assign in_ready  = w_en;
  assign out_valid = r_v3;
  assign p         = r_p;
  assign out_tag   = r_tag3;

  // -2^(WIDTH-1) negates to itself, which reads correctly as an unsigned magnitude.
  always_comb begin
    w_a_neg = in_signed & a[WIDTH-1];
    w_b_neg = in_signed & b[WIDTH-1];
    w_ma    = w_a_neg ? -a : a;
    w_mb    = w_b_neg ? -b : b;
  end

  vedic_nxn #(.N(H)) u_q0 (.a(r_ma[H-1:0]),     .b(r_mb[H-1:0]),     .p(w_q0));
  vedic_nxn #(.N(H)) u_q1 (.a(r_ma[WIDTH-1:H]), .b(r_mb[H-1:0]),     .p(w_q1));
  vedic_nxn #(.N(H)) u_q2 (.a(r_ma[H-1:0]),     .b(r_mb[WIDTH-1:H]), .p(w_q2));
  vedic_nxn #(.N(H)) u_q3 (.a(r_ma[WIDTH-1:H]), .b(r_mb[WIDTH-1:H]), .p(w_q3));

  always_comb begin
    w_sum  = {r_q3, r_q0}
           + {{H{1'b0}}, r_q1, {H{1'b0}}}
           + {{H{1'b0}}, r_q2, {H{1'b0}}};
    w_prod = r_neg2 ? -w_sum : w_sum;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v1   <= 1'b0;
      r_v2   <= 1'b0;
      r_v3   <= 1'b0;
      r_ma   <= '0;
      r_mb   <= '0;
      r_neg1 <= 1'b0;
      r_neg2 <= 1'b0;
      r_tag1 <= '0;
      r_tag2 <= '0;
      r_tag3 <= '0;
      r_q0   <= '0;
      r_q1   <= '0;
      r_q2   <= '0;
      r_q3   <= '0;
      r_p    <= '0;
    end else if (w_en) begin
      r_v1   <= in_valid;
      r_ma   <= w_ma;
      r_mb   <= w_mb;
      r_neg1 <= w_a_neg ^ w_b_neg;
      r_tag1 <= in_tag;
      r_v2   <= r_v1;
      r_q0   <= w_q0;
      r_q1   <= w_q1;
      r_q2   <= w_q2;
      r_q3   <= w_q3;
      r_neg2 <= r_neg1;
      r_tag2 <= r_tag1;
      r_v3   <= r_v2;
      r_p    <= w_prod;
      r_tag3 <= r_tag2;
    end
  end

endmodule

// File: tb/tb_vedic_mult_pipe.sv
// Scoreboard bench: WIDTH=8/16/32 instances share control and operand bits;
// expected products are queued at input handshake and compared at output.
module tb_vedic_mult_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_signed;
  logic        out_ready;
  logic [31:0] av, bv;
  logic [3:0]  tag;

  logic        ir8, ir16, ir32, ov8, ov16, ov32;
  logic [15:0] p8;
  logic [31:0] p16;
  logic [63:0] p32;
  logic [3:0]  ot8, ot16, ot32;

  always #5 clk = ~clk;

  vedic_mult_pipe #(.WIDTH(8), .TAG_W(4)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir8),
    .in_signed(in_signed), .a(av[7:0]), .b(bv[7:0]), .in_tag(tag),
    .out_valid(ov8), .out_ready(out_ready), .p(p8), .out_tag(ot8));

  vedic_mult_pipe #(.WIDTH(16), .TAG_W(4)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir16),
    .in_signed(in_signed), .a(av[15:0]), .b(bv[15:0]), .in_tag(tag),
    .out_valid(ov16), .out_ready(out_ready), .p(p16), .out_tag(ot16));

  vedic_mult_pipe #(.WIDTH(32), .TAG_W(4)) u_dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir32),
    .in_signed(in_signed), .a(av), .b(bv), .in_tag(tag),
    .out_valid(ov32), .out_ready(out_ready), .p(p32), .out_tag(ot32));

  typedef struct {
    logic [15:0] p8;
    logic [31:0] p16;
    logic [63:0] p32;
    logic [3:0]  tag;
    int          cyc;
    bit          lat;
  } exp_t;

  exp_t        sb[$];
  int          n_chk = 0;
  int          n_err = 0;
  int          cyc = 0;
  bit          lat_chk = 1'b0;
  bit          hold = 1'b0;
  logic [15:0] hp;
  logic [3:0]  ht;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] mul_ref(input logic [31:0] x, input logic [31:0] y,
                                          input int w, input bit s);
    logic [63:0] m;
    longint      xe, ye;
    m  = (64'd1 << w) - 64'd1;
    xe = longint'({32'h0, x} & m);
    ye = longint'({32'h0, y} & m);
    if (s && x[w-1]) xe = xe - (longint'(1) << w);
    if (s && y[w-1]) ye = ye - (longint'(1) << w);
    return 64'(xe * ye) & ((64'd1 << (2 * w)) - 64'd1);
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      sb.delete();
      hold = 1'b0;
      check("rst_in_ready", ir8, 1);
      check("rst_out_valid", {ov8, ov16, ov32}, 0);
      check("rst_p", p8, 0);
      check("rst_tag", ot8, 0);
    end else begin
      if (hold) begin
        check("hold_valid", ov8, 1);
        check("hold_p", p8, hp);
        check("hold_tag", ot8, ht);
      end
      hold = ov8 && !out_ready;
      hp   = p8;
      ht   = ot8;
      if ((ov8 || ov16 || ov32) && out_ready) begin
        if (sb.size() == 0) begin
          check("spurious_out", 1, 0);
        end else begin
          e = sb.pop_front();
          check("valid_all", {ov8, ov16, ov32}, 3'b111);
          check("p8", p8, e.p8);
          check("p16", p16, e.p16);
          check("p32", p32, e.p32);
          check("tag", {ot8, ot16, ot32}, {e.tag, e.tag, e.tag});
          if (e.lat) check("latency", cyc - e.cyc, 3);
        end
      end
      if (in_valid && ir8) begin
        e.p8  = 16'(mul_ref(av, bv, 8, in_signed));
        e.p16 = 32'(mul_ref(av, bv, 16, in_signed));
        e.p32 = mul_ref(av, bv, 32, in_signed);
        e.tag = tag;
        e.cyc = cyc;
        e.lat = lat_chk;
        sb.push_back(e);
      end
    end
  end

  task automatic drive(input bit v, input bit s, input logic [31:0] x, input logic [31:0] y,
                       input logic [3:0] t, input bit ordy, output bit acc);
    in_valid  = v;
    in_signed = s;
    av        = x;
    bv        = y;
    tag       = t;
    out_ready = ordy;
    @(negedge clk);
    acc = v && ir8;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    bit acc;
    for (int i = 0; i < 40 && sb.size() != 0; i++) drive(0, 0, '0, '0, '0, 1, acc);
    check(name, sb.size(), 0);
  endtask

  initial begin
    bit acc;
    int sent;
    rst = 1'b1;
    in_valid = 1'b0; in_signed = 1'b0; out_ready = 1'b1;
    av = '0; bv = '0; tag = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    lat_chk = 1'b1;
    for (int i = 0; i < 256; i++) drive(1, 0, 32'(i), 32'(i), 4'(i), 1, acc);
    drain("drain_sweep");

    drive(1, 1, 32'hFFFF_FF80, 32'hFFFF_FF80, 4'h1, 1, acc);
    drive(1, 1, 32'hFFFF_FFFF, 32'h0000_0001, 4'h2, 1, acc);
    drive(1, 1, 32'h0000_007F, 32'hFFFF_FF80, 4'h3, 1, acc);
    drive(1, 0, 32'h0000_00FF, 32'h0000_0080, 4'h4, 1, acc);
    drive(1, 1, 32'h8000_0000, 32'h8000_0000, 4'h5, 1, acc);
    drive(1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'h6, 1, acc);
    drain("drain_signed");

    lat_chk = 1'b0;
    sent = 0;
    for (int c = 0; c < 40 && sent < 8; c++) begin
      drive(1, 0, 32'(sent + 1), 32'd3, 4'(sent), !(c >= 3 && c < 8), acc);
      if (acc) sent++;
    end
    check("bp_sent", sent, 8);
    drain("drain_bp");

    sent = 0;
    in_valid = 1'b0;
    for (int c = 0; c < 12; c++) begin
      out_ready = !(c >= 4 && c < 9);
      in_valid  = 1'b1;
      tag       = 4'(8 + sent);
      av        = 32'(sent);
      bv        = 32'd5;
      @(negedge clk);
      if (!out_ready && ov8) check("stall_in_ready", ir8, 0);
      if (ir8) sent++;
      @(posedge clk);
      #1;
    end
    drain("drain_stall");

    lat_chk = 1'b1;
    for (int i = 0; i < 3; i++) drive(1, 0, 32'(i + 2), 32'd9, 4'(i), 1, acc);
    rst = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, '0, '0, '0, 1, acc);
      check("post_rst_idle", ov8, 0);
    end
    drive(1, 0, 32'd5, 32'd7, 4'hA, 1, acc);
    for (int i = 0; i < 2; i++) drive(0, 0, '0, '0, '0, 1, acc);
    @(negedge clk);
    check("post_rst_p", {ov8, p8}, {1'b1, 16'd35});
    @(posedge clk);
    #1;
    drain("drain_rst");

    lat_chk = 1'b0;
    for (int i = 0; i < 800; i++)
      drive($urandom_range(0, 3) != 0, 1'($urandom), $urandom, $urandom, 4'($urandom),
            $urandom_range(0, 3) != 0, acc);
    drain("drain_rand");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
